line_clear: RTL

//  Post-lock board compaction stage, upstream of the board RAM redraw. After a tetromino is

---
 rtl/line_clear.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/line_clear.sv
// line_clear: post-lock board compaction. Scans the board bottom-up, drops
// full rows, shifts surviving rows down and zero-fills the vacated top rows,
// then pulses done. It owns the board RAM port for the whole pass.
module line_clear #(
    parameter int COLS = 10,
    parameter int ROWS = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] ram_q,
    output logic [7:0] ram_addr,
    output logic [5:0] ram_data,
    output logic       ram_wren,
    output logic       busy,
    output logic       done,
    output logic [4:0] lines_cleared
);

    typedef enum logic [2:0] {IDLE, CHECK, COPY, FILL, DONE} state_t;

    state_t     state;
    logic [5:0] src;
    logic [5:0] dst;
    logic [4:0] col;
    logic       phase;
    logic       full_acc;
    logic       copy_wr;

    logic       cell_ok;
    logic       row_full;
    logic [4:0] lines_inc;

    // Linear board address of cell (r, c) in 8-bit arithmetic.
    function automatic logic [7:0] cell_addr(input logic [5:0] r, input logic [4:0] c);
        return ({2'b00, r} * 8'(COLS)) + {3'b000, c};
    endfunction

    assign cell_ok   = (ram_q != 6'd0);
    assign row_full  = full_acc & cell_ok;
    assign lines_inc = lines_cleared + 5'd1;

    // Copy writes forward the read data straight from the RAM output, since it
    // only becomes valid in the write cycle itself; every other write is zero.
    assign ram_data = copy_wr ? ram_q : 6'd0;

    // Compaction sequencer: the column counter doubles as the read step in CHECK,
    // where the row verdict lands one cycle after the last column read.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            src           <= 6'd0;
            dst           <= 6'd0;
            col           <= 5'd0;
            phase         <= 1'b0;
            full_acc      <= 1'b1;
            copy_wr       <= 1'b0;
            ram_addr      <= 8'd0;
            ram_wren      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            lines_cleared <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    done     <= 1'b0;
                    ram_wren <= 1'b0;
                    copy_wr  <= 1'b0;
                    if (start) begin
                        src           <= 6'(ROWS - 1);
                        dst           <= 6'(ROWS - 1);
                        col           <= 5'd0;
                        full_acc      <= 1'b1;
                        lines_cleared <= 5'd0;
                        busy          <= 1'b1;
                        ram_addr      <= cell_addr(6'(ROWS - 1), 5'd0);
                        state         <= CHECK;
                    end
                end

                CHECK: begin
                    if (col != 5'd0)
                        full_acc <= row_full;
                    if (col < 5'(COLS - 1))
                        ram_addr <= cell_addr(src, col + 5'd1);
                    if (col != 5'(COLS)) begin
                        col <= col + 5'd1;
                    end else begin
                        col      <= 5'd0;
                        full_acc <= 1'b1;
                        if (row_full) begin
                            lines_cleared <= lines_inc;
                            if (src == 6'd0) begin
                                ram_addr <= cell_addr(dst, 5'd0);
                                ram_wren <= 1'b1;
                                state    <= FILL;
                            end else begin
                                src      <= src - 6'd1;
                                ram_addr <= cell_addr(src - 6'd1, 5'd0);
                            end
                        end else if (src == dst) begin
                            // No row has been cleared yet, so reaching the top
                            // here leaves nothing to fill.
                            if (src == 6'd0) begin
                                ram_addr <= 8'd0;
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                state    <= DONE;
                            end else begin
                                src      <= src - 6'd1;
                                dst      <= dst - 6'd1;
                                ram_addr <= cell_addr(src - 6'd1, 5'd0);
                            end
                        end else begin
                            phase    <= 1'b0;
                            ram_addr <= cell_addr(src, 5'd0);
                            state    <= COPY;
                        end
                    end
                end

                COPY: begin
                    if (!phase) begin
                        ram_addr <= cell_addr(dst, col);
                        ram_wren <= 1'b1;
                        copy_wr  <= 1'b1;
                        phase    <= 1'b1;
                    end else begin
                        ram_wren <= 1'b0;
                        copy_wr  <= 1'b0;
                        phase    <= 1'b0;
                        if (col == 5'(COLS - 1)) begin
                            col <= 5'd0;
                            dst <= dst - 6'd1;
                            if (src == 6'd0) begin
                                ram_addr <= cell_addr(dst - 6'd1, 5'd0);
                                ram_wren <= 1'b1;
                                state    <= FILL;
                            end else begin
                                src      <= src - 6'd1;
                                full_acc <= 1'b1;
                                ram_addr <= cell_addr(src - 6'd1, 5'd0);
                                state    <= CHECK;
                            end
                        end else begin
                            col      <= col + 5'd1;
                            ram_addr <= cell_addr(src, col + 5'd1);
                        end
                    end
                end

                FILL: begin
                    if (col == 5'(COLS - 1)) begin
                        col <= 5'd0;
                        if (dst == 6'd0) begin
                            ram_wren <= 1'b0;
                            ram_addr <= 8'd0;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= DONE;
                        end else begin
                            dst      <= dst - 6'd1;
                            ram_addr <= cell_addr(dst - 6'd1, 5'd0);
                        end
                    end else begin
                        col      <= col + 5'd1;
                        ram_addr <= cell_addr(dst, col + 5'd1);
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
